axi_dma_rd_aligned: RTL

AXI_DMA_RD_ALIGNED -- requirements
Module: axi_dma_rd_aligned

---
 rtl/axi_dma_pkg.sv | 22 ++
 rtl/axi_dma_rd_out_reg.sv | 88 ++++++++
 rtl/axi_dma_rd_aligned.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_pkg.sv
// Shared AXI encodings and constants for the DMA read engines.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;
  localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
  localparam logic [2:0] AXI_PROT_DATA_NS  = 3'b010;

  // Bursts must never cross this address boundary.
  localparam int AXI_BOUNDARY_BYTES = 4096;
  localparam int AXI_BOUNDARY_LOG2  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_dma_rd_out_reg.sv
// Registered AXI-stream output stage; accepts a beat whenever empty or draining.
module axi_dma_rd_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic [ID_W-1:0]   out_id,
  output logic [DEST_W-1:0] out_dest,
  output logic [USER_W-1:0] out_user
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [USER_W-1:0] user_q, user_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    id_d    = id_q;
    dest_d  = dest_q;
    user_d  = user_q;
    if (in_valid) begin
      valid_d = 1'b1;
      data_d  = in_data;
      keep_d  = in_keep;
      last_d  = in_last;
      id_d    = in_id;
      dest_d  = in_dest;
      user_d  = in_user;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_id    = id_q;
  assign out_dest  = dest_q;
  assign out_user  = user_q;

endmodule

// File: rtl/axi_dma_rd_aligned.sv
// Aligned-only AXI read DMA: one descriptor at a time, split into 4 KB-safe bursts,
// streamed out through a registered AXI-stream stage.
//   state    | meaning
//   ST_IDLE  | waiting for a descriptor (ready when enable is high)
//   ST_ISSUE | issuing AR bursts, R beats may already be returning
//   ST_DRAIN | all ARs accepted, collecting the remaining R beats
module axi_dma_rd_aligned
  import axi_dma_pkg::*;
#(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH      = 8,
  parameter int AXI_MAX_BURST_LEN = 16,
  parameter int AXIS_ID_WIDTH     = 8,
  parameter int AXIS_DEST_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH   = 1,
  parameter int LEN_WIDTH         = 20,
  parameter int TAG_WIDTH         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_read_desc_addr,
  input  logic [LEN_WIDTH-1:0]       s_axis_read_desc_len,
  input  logic [TAG_WIDTH-1:0]       s_axis_read_desc_tag,
  input  logic [AXIS_ID_WIDTH-1:0]   s_axis_read_desc_id,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_read_desc_dest,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_read_desc_user,
  input  logic                       s_axis_read_desc_valid,
  output logic                       s_axis_read_desc_ready,
  output logic [TAG_WIDTH-1:0]       m_axis_read_desc_status_tag,
  output logic [1:0]                 m_axis_read_desc_status_error,
  output logic                       m_axis_read_desc_status_valid,
  output logic [AXI_DATA_WIDTH-1:0]  m_axis_read_data_tdata,
  output logic [AXI_STRB_WIDTH-1:0]  m_axis_read_data_tkeep,
  output logic                       m_axis_read_data_tvalid,
  input  logic                       m_axis_read_data_tready,
  output logic                       m_axis_read_data_tlast,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_read_data_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_read_data_tdest,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_read_data_tuser,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  input  logic                       enable
);

  localparam int OFFS_W = $clog2(AXI_STRB_WIDTH);
  localparam int BND_W  = AXI_BOUNDARY_LOG2 + 1;
  localparam logic [LEN_WIDTH-1:0] OFFS_MASK = LEN_WIDTH'(AXI_STRB_WIDTH - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0] MAX_BEATS = LEN_WIDTH'(AXI_MAX_BURST_LEN);

  rd_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       issue_rem_q, issue_rem_d;
  logic [LEN_WIDTH-1:0]       rx_rem_q, rx_rem_d;
  logic [AXI_STRB_WIDTH-1:0]  last_keep_q, last_keep_d;
  logic [TAG_WIDTH-1:0]       tag_q, tag_d;
  logic [AXIS_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;
  logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
  logic [1:0]                 err_q, err_d;
  logic                       status_valid_q, status_valid_d;
  logic                       arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [7:0]                 arlen_q, arlen_d;

  logic                       busy;
  logic                       desc_hs, ar_hs, r_hs, ar_load, rx_final;
  logic                       out_in_ready;
  logic [LEN_WIDTH-1:0]       desc_rem, desc_beats, burst_beats, bound_beats;
  logic [BND_W-1:0]           bound_bytes;
  logic                       unused_r;

  assign unused_r = ^{m_axi_rid, m_axi_rlast};

  assign desc_hs  = s_axis_read_desc_valid && s_axis_read_desc_ready;
  assign ar_hs    = arvalid_q && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign rx_final = r_hs && (rx_rem_q == LEN_WIDTH'(1));
  // Back-to-back bursts: the next AR loads in the same cycle the current one is accepted.
  assign ar_load  = (state_q == ST_ISSUE) && (issue_rem_q != '0) && (!arvalid_q || m_axi_arready);

  assign desc_rem   = s_axis_read_desc_len & OFFS_MASK;
  assign desc_beats = (s_axis_read_desc_len >> OFFS_W) + LEN_WIDTH'(desc_rem != '0);

  assign bound_bytes = BND_W'(AXI_BOUNDARY_BYTES) - {1'b0, addr_q[AXI_BOUNDARY_LOG2-1:0]};
  assign bound_beats = LEN_WIDTH'(bound_bytes >> OFFS_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (desc_hs && (s_axis_read_desc_len != '0)) state_d = ST_ISSUE;
      ST_ISSUE: if (ar_hs && (issue_rem_q == '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (rx_final) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy                   = (state_q != ST_IDLE);
    s_axis_read_desc_ready = (state_q == ST_IDLE) && enable && !rst;
    m_axi_rready           = busy && out_in_ready;
  end

  always_comb begin
    burst_beats = issue_rem_q;
    if (burst_beats > MAX_BEATS)   burst_beats = MAX_BEATS;
    if (burst_beats > bound_beats) burst_beats = bound_beats;

    addr_d         = addr_q;
    issue_rem_d    = issue_rem_q;
    rx_rem_d       = rx_rem_q;
    last_keep_d    = last_keep_q;
    tag_d          = tag_q;
    id_d           = id_q;
    dest_d         = dest_q;
    user_d         = user_q;
    err_d          = err_q;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    status_valid_d = (desc_hs && (s_axis_read_desc_len == '0)) || rx_final;

    if (desc_hs) begin
      addr_d      = s_axis_read_desc_addr & ADDR_MASK;
      issue_rem_d = desc_beats;
      rx_rem_d    = desc_beats;
      last_keep_d = (desc_rem == '0) ? '1 : ~({AXI_STRB_WIDTH{1'b1}} << desc_rem);
      tag_d       = s_axis_read_desc_tag;
      id_d        = s_axis_read_desc_id;
      dest_d      = s_axis_read_desc_dest;
      user_d      = s_axis_read_desc_user;
      err_d       = AXI_RESP_OKAY;
    end

    if (ar_load) begin
      arvalid_d   = 1'b1;
      araddr_d    = addr_q;
      arlen_d     = 8'(burst_beats - LEN_WIDTH'(1));
      addr_d      = addr_q + (AXI_ADDR_WIDTH'(burst_beats) << OFFS_W);
      issue_rem_d = issue_rem_q - burst_beats;
    end else if (ar_hs) begin
      arvalid_d = 1'b0;
    end

    if (r_hs) begin
      rx_rem_d = rx_rem_q - LEN_WIDTH'(1);
      if (err_q == AXI_RESP_OKAY) err_d = m_axi_rresp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      issue_rem_q    <= '0;
      rx_rem_q       <= '0;
      last_keep_q    <= '0;
      tag_q          <= '0;
      id_q           <= '0;
      dest_q         <= '0;
      user_q         <= '0;
      err_q          <= '0;
      status_valid_q <= 1'b0;
      arvalid_q      <= 1'b0;
      araddr_q       <= '0;
      arlen_q        <= '0;
    end else begin
      addr_q         <= addr_d;
      issue_rem_q    <= issue_rem_d;
      rx_rem_q       <= rx_rem_d;
      last_keep_q    <= last_keep_d;
      tag_q          <= tag_d;
      id_q           <= id_d;
      dest_q         <= dest_d;
      user_q         <= user_d;
      err_q          <= err_d;
      status_valid_q <= status_valid_d;
      arvalid_q      <= arvalid_d;
      araddr_q       <= araddr_d;
      arlen_q        <= arlen_d;
    end
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(OFFS_W);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_BUF_MOD;
  assign m_axi_arprot  = AXI_PROT_DATA_NS;
  assign m_axi_arvalid = arvalid_q;

  assign m_axis_read_desc_status_tag   = tag_q;
  assign m_axis_read_desc_status_error = err_q;
  assign m_axis_read_desc_status_valid = status_valid_q;

  // Beat position comes from the descriptor count, never from rlast.
  axi_dma_rd_out_reg #(
    .DATA_W (AXI_DATA_WIDTH),
    .KEEP_W (AXI_STRB_WIDTH),
    .ID_W   (AXIS_ID_WIDTH),
    .DEST_W (AXIS_DEST_WIDTH),
    .USER_W (AXIS_USER_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_hs),
    .in_ready  (out_in_ready),
    .in_data   (m_axi_rdata),
    .in_keep   ((rx_rem_q == LEN_WIDTH'(1)) ? last_keep_q : {AXI_STRB_WIDTH{1'b1}}),
    .in_last   (rx_rem_q == LEN_WIDTH'(1)),
    .in_id     (id_q),
    .in_dest   (dest_q),
    .in_user   (user_q),
    .out_valid (m_axis_read_data_tvalid),
    .out_ready (m_axis_read_data_tready),
    .out_data  (m_axis_read_data_tdata),
    .out_keep  (m_axis_read_data_tkeep),
    .out_last  (m_axis_read_data_tlast),
    .out_id    (m_axis_read_data_tid),
    .out_dest  (m_axis_read_data_tdest),
    .out_user  (m_axis_read_data_tuser)
  );

endmodule
